// File: rtl/alu_issue_stage.sv
// Issue stage for an external 32-bit ALU: operand register on the ALU inputs, result FIFO on its outputs,
// plus NZCV status, sticky overflow and a retired-op counter. Define ALU_ISSUE_TAG_EN to carry a per-op tag.
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
`ifdef ALU_ISSUE_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_f,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal,
    output logic [3:0]       status_nzcv,
    output logic             sticky_v,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_ISSUE_TAG_EN
    ,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]      LP_FULL    = (PW+1)'(DEPTH);
    localparam logic [PW:0]      LP_CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]    LP_PTR_ONE = PW'(1);
    localparam logic [CNT_W-1:0] LP_OP_ONE  = CNT_W'(1);

    logic             r_s1Valid;
    logic [31:0]      r_s1A;
    logic [31:0]      r_s1B;
    logic [2:0]       r_s1F;
    logic [31:0]      r_memResult [DEPTH];
    logic [3:0]       r_memFlags [DEPTH];
    logic             r_memIllegal [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW:0]      r_count;
    logic [3:0]       r_status;
    logic             r_sticky;
    logic [CNT_W-1:0] r_opCount;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_advance;
    logic             w_accept;
    logic             w_legal;
    logic [31:0]      w_pushResult;
    logic [3:0]       w_pushFlags;

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_FULL);
    assign w_pop     = !w_empty && out_ready;
    assign w_advance = r_s1Valid && (!w_full || w_pop);
    assign in_ready  = !r_s1Valid || w_advance;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_legal = 1'b0;
        case (r_s1F)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd5: w_legal = 1'b1;
            default:                      w_legal = 1'b0;
        endcase
    end

    // Illegal ops are recorded as a zero result with only Z set.
    assign w_pushResult = w_legal ? alu_result : '0;
    assign w_pushFlags  = w_legal ? {alu_negative, alu_zero, alu_carry, alu_overflow} : 4'b0100;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1F     <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1A     <= in_a;
            r_s1B     <= in_b;
            r_s1F     <= in_f;
        end else if (w_advance) begin
            r_s1Valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance && !reset) begin
            r_memResult[r_wrPtr]  <= w_pushResult;
            r_memFlags[r_wrPtr]   <= w_pushFlags;
            r_memIllegal[r_wrPtr] <= !w_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_advance) r_wrPtr <= r_wrPtr + LP_PTR_ONE;
            if (w_pop)     r_rdPtr <= r_rdPtr + LP_PTR_ONE;
            case ({w_advance, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A legal overflow in the same cycle as a clear keeps the sticky bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status  <= '0;
            r_sticky  <= 1'b0;
            r_opCount <= '0;
        end else begin
            if (w_advance) r_opCount <= r_opCount + LP_OP_ONE;
            if (w_advance && w_legal) r_status <= w_pushFlags;
            if (w_advance && w_legal && w_pushFlags[0]) r_sticky <= 1'b1;
            else if (clear_sticky)                      r_sticky <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_TAG_EN
    logic [TAG_W-1:0] r_s1Tag;
    logic [TAG_W-1:0] r_memTag [DEPTH];

    always_ff @(posedge clk) begin
        if (reset)         r_s1Tag <= '0;
        else if (w_accept) r_s1Tag <= in_tag;
    end

    always_ff @(posedge clk) begin
        if (w_advance && !reset) r_memTag[r_wrPtr] <= r_s1Tag;
    end

    assign out_tag = w_empty ? '0 : r_memTag[r_rdPtr];
`endif

    assign alu_a       = r_s1A;
    assign alu_b       = r_s1B;
    assign alu_f       = r_s1F;
    assign out_valid   = !w_empty;
    assign out_result  = w_empty ? '0 : r_memResult[r_rdPtr];
    assign out_flags   = w_empty ? '0 : r_memFlags[r_rdPtr];
    assign out_illegal = w_empty ? 1'b0 : r_memIllegal[r_rdPtr];
    assign status_nzcv = r_status;
    assign sticky_v    = r_sticky;
    assign op_count    = r_opCount;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: bench-side ALU, queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_stage;
    localparam int DEPTH    = 2;
    localparam int TB_CNT_W = 5;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  fl;
        logic        ill;
    } entry_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [31:0]         in_a = '0;
    logic [31:0]         in_b = '0;
    logic [2:0]          in_f = '0;
    logic [31:0]         alu_a;
    logic [31:0]         alu_b;
    logic [2:0]          alu_f;
    logic [31:0]         alu_result;
    logic                alu_zero;
    logic                alu_overflow;
    logic                alu_carry;
    logic                alu_negative;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [31:0]         out_result;
    logic [3:0]          out_flags;
    logic                out_illegal;
    logic [3:0]          status_nzcv;
    logic                sticky_v;
    logic                clear_sticky = 1'b0;
    logic [TB_CNT_W-1:0] op_count;

    int checks = 0;
    int failures = 0;

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_negative(alu_negative),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_illegal(out_illegal),
        .status_nzcv(status_nzcv), .sticky_v(sticky_v), .clear_sticky(clear_sticky),
        .op_count(op_count)
    );

    initial forever #5 clk = ~clk;

    // Reference ALU: returns {result, N, Z, C, V}; illegal codes produce junk the stage must mask.
    function automatic logic [35:0] aluCalc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [32:0] s;
        logic [31:0] r;
        logic c;
        logic v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (f)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return {a ^ b, 4'b1111};
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    logic [35:0] aluOut;
    assign aluOut       = aluCalc(alu_a, alu_b, alu_f);
    assign alu_result   = aluOut[35:4];
    assign alu_negative = aluOut[3];
    assign alu_zero     = aluOut[2];
    assign alu_carry    = aluOut[1];
    assign alu_overflow = aluOut[0];

    function automatic logic isLegal(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd3) || (f == 3'd5);
    endfunction

    function automatic entry_t expEntry(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        entry_t e;
        logic [35:0] calc;
        calc = aluCalc(a, b, f);
        if (isLegal(f)) begin
            e.r = calc[35:4]; e.fl = calc[3:0]; e.ill = 1'b0;
        end else begin
            e.r = '0; e.fl = 4'b0100; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: S1 slot, FIFO queue and architectural state, advanced once per cycle.
    bit                  modelValid = 1'b0;
    bit                  mS1Valid;
    logic [31:0]         mS1A;
    logic [31:0]         mS1B;
    logic [2:0]          mS1F;
    entry_t              mFifo[$];
    logic [3:0]          mStatus;
    bit                  mSticky;
    logic [TB_CNT_W-1:0] mCount;

    initial begin
        entry_t head;
        entry_t newE;
        bit pop;
        bit adv;
        bit rdy;
        forever begin
            @(negedge clk);
            pop = (mFifo.size() != 0) && out_ready;
            adv = mS1Valid && ((mFifo.size() < DEPTH) || pop);
            rdy = !mS1Valid || adv;
            head = (mFifo.size() != 0) ? mFifo[0] : entry_t'(0);
            if (modelValid) begin
                checkOutput("in_ready", 64'(in_ready), 64'(rdy));
                checkOutput("out_valid", 64'(out_valid), 64'(mFifo.size() != 0));
                checkOutput("out_result", 64'(out_result), 64'(head.r));
                checkOutput("out_flags", 64'(out_flags), 64'(head.fl));
                checkOutput("out_illegal", 64'(out_illegal), 64'(head.ill));
                checkOutput("status_nzcv", 64'(status_nzcv), 64'(mStatus));
                checkOutput("sticky_v", 64'(sticky_v), 64'(mSticky));
                checkOutput("op_count", 64'(op_count), 64'(mCount));
                checkOutput("alu_a", 64'(alu_a), 64'(mS1A));
                checkOutput("alu_b", 64'(alu_b), 64'(mS1B));
                checkOutput("alu_f", 64'(alu_f), 64'(mS1F));
            end
            if (reset) begin
                mS1Valid = 1'b0; mS1A = '0; mS1B = '0; mS1F = '0;
                mFifo.delete();
                mStatus = '0; mSticky = 1'b0; mCount = '0;
                modelValid = 1'b1;
            end else if (modelValid) begin
                newE = expEntry(mS1A, mS1B, mS1F);
                if (pop) void'(mFifo.pop_front());
                if (adv) begin
                    mFifo.push_back(newE);
                    mCount = mCount + 1'b1;
                    if (!newE.ill) mStatus = newE.fl;
                end
                if (adv && !newE.ill && newE.fl[0]) mSticky = 1'b1;
                else if (clear_sticky)              mSticky = 1'b0;
                if (in_valid && rdy) begin
                    mS1Valid = 1'b1; mS1A = in_a; mS1B = in_b; mS1F = in_f;
                end else if (adv) begin
                    mS1Valid = 1'b0;
                end
            end
        end
    end

    // Presents one op and holds it until the stage accepts it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_f = f;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #2;
        end
        checkOutput("accept_in_time", 64'(done), 64'(1));
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_op_count", 64'(op_count), 64'(0));

        // ADD overflow into the sign bit
        @(posedge clk); #2 out_ready = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h1, 3'd0);
        @(negedge clk);
        checkOutput("t1_valid_early", 64'(out_valid), 64'(0));
        @(negedge clk);
        checkOutput("t1_valid", 64'(out_valid), 64'(1));
        checkOutput("t1_result", 64'(out_result), 64'(32'h8000_0000));
        checkOutput("t1_flags", 64'(out_flags), 64'(4'b1001));
        checkOutput("t1_status", 64'(status_nzcv), 64'(4'b1001));
        checkOutput("t1_sticky", 64'(sticky_v), 64'(1));
        checkOutput("t1_count", 64'(op_count), 64'(1));

        // back-to-back SUB then SLT
        @(posedge clk); #2;
        applyStimulus(32'd5, 32'd5, 3'd1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'd5);
        @(negedge clk);
        checkOutput("t2_sub_result", 64'(out_result), 64'(0));
        checkOutput("t2_sub_z", 64'(out_flags[2]), 64'(1));
        @(negedge clk);
        checkOutput("t2_slt_result", 64'(out_result), 64'(1));
        checkOutput("t2_count", 64'(op_count), 64'(3));

        // backpressure: FIFO fills, S1 holds the third op, fourth waits
        @(posedge clk); #2 out_ready = 1'b0;
        fork
            begin
                applyStimulus(32'd1, 32'd2, 3'd0);
                applyStimulus(32'd10, 32'd20, 3'd0);
                applyStimulus(32'h0000_FF0F, 32'h0000_0FF0, 3'd2);
                applyStimulus(32'h0000_00F0, 32'h0000_000F, 3'd3);
            end
            begin
                repeat (6) @(negedge clk);
                checkOutput("t3_in_ready_stalled", 64'(in_ready), 64'(0));
                checkOutput("t3_head", 64'(out_result), 64'(3));
                checkOutput("t3_count_stalled", 64'(op_count), 64'(5));
                @(posedge clk); #2 out_ready = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        checkOutput("t3_drained", 64'(out_valid), 64'(0));
        checkOutput("t3_count", 64'(op_count), 64'(7));

        // illegal op leaves status alone
        @(posedge clk); #2;
        applyStimulus(32'd1, 32'd2, 3'd1);
        applyStimulus(32'd3, 32'd4, 3'd6);
        @(negedge clk);
        checkOutput("t4_sub_result", 64'(out_result), 64'(32'hFFFF_FFFF));
        @(negedge clk);
        checkOutput("t4_ill_result", 64'(out_result), 64'(0));
        checkOutput("t4_ill_flags", 64'(out_flags), 64'(4'b0100));
        checkOutput("t4_ill_flag", 64'(out_illegal), 64'(1));
        checkOutput("t4_status", 64'(status_nzcv), 64'(4'b1000));
        checkOutput("t4_count", 64'(op_count), 64'(9));

        // sticky set wins over clear, then clear alone
        @(posedge clk); #2;
        applyStimulus(32'h8000_0000, 32'h8000_0000, 3'd0);
        clear_sticky = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        @(negedge clk);
        checkOutput("t5_flags", 64'(out_flags), 64'(4'b0111));
        checkOutput("t5_sticky_kept", 64'(sticky_v), 64'(1));
        @(posedge clk); #2 clear_sticky = 1'b0;
        @(negedge clk);
        checkOutput("t5_sticky_cleared", 64'(sticky_v), 64'(0));

        // reset with a full FIFO and a held op
        @(posedge clk); #2 out_ready = 1'b0;
        applyStimulus(32'd7, 32'd8, 3'd0);
        applyStimulus(32'd9, 32'd1, 3'd1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 3'd0);
        reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_out_valid", 64'(out_valid), 64'(0));
        checkOutput("t6_in_ready", 64'(in_ready), 64'(1));
        checkOutput("t6_status", 64'(status_nzcv), 64'(0));
        checkOutput("t6_count", 64'(op_count), 64'(0));
        checkOutput("t6_alu", 64'({alu_a, alu_b[28:0], alu_f}), 64'(0));

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            in_valid     = ($urandom_range(0, 2) != 0);
            in_a         = pickOperand();
            in_b         = pickOperand();
            in_f         = 3'($urandom_range(0, 7));
            out_ready    = ($urandom_range(0, 3) != 0);
            clear_sticky = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0; reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("final_drained", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
